uart_rx_frame_parser: RTL and testbench
=======================================

// Module: uart_rx_frame_parser
// PURPOSE
//  Downstream consumer of the UART driver's user RX byte stream (rx_data/rx_valid), in the
//  user clock domain. Finds frames HEAD0 HEAD1 LEN PAYLOAD[LEN] CHK, streams payload bytes
//  out and reports each frame as OK or ERR. CHK = 8-bit sum (mod 256) of LEN and all
//  payload bytes. No backpressure: the UART cannot stall, so every input byte is consumed.
// PARAMETERS
//  P_DATA_WIDTH   8       byte width; all header/LEN/CHK fields are this width
//  P_HEAD0        8'h55   first header byte
//  P_HEAD1        8'hAA   second header byte
//  P_MAX_LEN      16      max legal LEN (1..P_MAX_LEN)
//  P_TIMEOUT_CYC  50000   inter-byte timeout, clk cycles (>=2)
// PORTS
//  clk           in   1    user clock
//  w_user_rst    in   1    async active-high reset
//  i_rx_data     in   8    received byte from UART driver
//  i_rx_valid    in   1    1-cycle strobe, byte valid
//  o_pld_data    out  8    payload byte
//  o_pld_valid   out  1    payload strobe
//  o_pld_last    out  1    with o_pld_valid on last payload byte
//  o_frame_ok    out  1    1-cycle pulse: checksum match
//  o_frame_err   out  1    1-cycle pulse: frame aborted/failed
//  o_err_code    out  2    0 none, 1 bad LEN, 2 checksum, 3 timeout; held until next ok/err
//  o_frame_cnt   out  16   count of OK frames, wraps 16'hFFFF->0
//  o_busy        out  1    1 when state != IDLE
// BEHAVIOUR
//  Reset: reset w_user_rst, asynchronous, active-high; clock clk. All outputs 0, state IDLE,
//   sum/len/timer counters 0. Reset mid-frame discards the frame; no pulse emitted.
//  All outputs registered: response appears 1 clk after the cycle i_rx_valid is sampled.
//  States / transitions (only on i_rx_valid unless noted):
//   IDLE:    data==P_HEAD0 -> HEAD1; else stay.
//   HEAD1:   data==P_HEAD1 -> LEN; data==P_HEAD0 -> stay HEAD1 (resync); else -> IDLE.
//            Header mismatch is silent (no err pulse).
//   LEN:     data==0 or data>P_MAX_LEN -> err code 1, IDLE; else cnt=data, sum=data -> PLD.
//   PLD:     emit byte on o_pld_data/valid, sum+=data, cnt-=1; at cnt==1 assert o_pld_last
//            and -> CHK.
//   CHK:     data==sum -> o_frame_ok, code 0, o_frame_cnt+1; else o_frame_err, code 2.
//            -> IDLE. Payload already emitted is not retracted; ERR tells consumer to drop.
//  A header byte inside PLD/CHK is treated as data (no resync mid-frame).
//  Timeout: timer cleared in IDLE and on each accepted byte; else +1 per clk. If state != IDLE
//   and timer==P_TIMEOUT_CYC-1 with no i_rx_valid: next clk o_frame_err, code 3, IDLE.
//   I.e. byte at cycle t, silence -> err pulse at t+P_TIMEOUT_CYC+1. i_rx_valid on the
//   threshold cycle wins: byte accepted, no timeout.
//  Sum arithmetic 8-bit, carries discarded. o_frame_ok and o_frame_err never both high.
//  After any ok/err/timeout, the very next byte is evaluated from IDLE.
// TESTING
//  1 Good: 55 AA 03 11 22 33 69 -> pld 11,22,33 (last on 33), ok pulse, code 0, cnt=1.
//  2 Bad CHK: 55 AA 03 11 22 33 68 -> 3 pld bytes emitted, err pulse, code 2, cnt unchanged.
//  3 LEN=00 and LEN=11(17): 55 AA 00 / 55 AA 11 -> err code 1, no pld, next good frame OK.
//  4 Resync: 55 55 AA 01 7E 7F -> pld 7E with last, ok; 55 12 AA .. -> silent drop.
//  5 Timeout (P_TIMEOUT_CYC=100): 55 AA 02 01 then idle -> err code 3 exactly 101 clk after
//    byte 01; byte on cycle 100 instead -> no timeout.
//  6 Reset asserted mid-PLD -> outputs 0 async, o_busy 0; good frame after release -> OK.

Source files
------------

// File: rtl/uart_rx_frame_parser.sv
// ----------------------------------------------------------------------------
// uart_rx_frame_parser
//
// Purpose:
//   Consumes the UART driver's user-domain RX byte stream and extracts frames of
//   the form HEAD0 HEAD1 LEN PAYLOAD[LEN] CHK. CHK is the 8-bit modulo-256 sum of
//   LEN and all payload bytes. Payload bytes are streamed out as they arrive.
//   Each frame is reported as OK or ERR. There is no backpressure, so every input
//   byte is consumed.
//
// Ports:
//   clk          in   user clock
//   w_user_rst   in   asynchronous, active-high reset
//   i_rx_data    in   received byte
//   i_rx_valid   in   one-cycle strobe that qualifies i_rx_data
//   o_pld_data   out  payload byte
//   o_pld_valid  out  payload strobe
//   o_pld_last   out  asserted with o_pld_valid on the last payload byte
//   o_frame_ok   out  one-cycle pulse when the checksum matches
//   o_frame_err  out  one-cycle pulse when a frame is aborted or fails
//   o_err_code   out  0 none, 1 bad LEN, 2 checksum, 3 timeout
//                     (held until the next ok/err)
//   o_frame_cnt  out  count of OK frames, wraps around
//   o_busy       out  high whenever the parser is not idle
//
// All outputs are registered. The response to a byte appears one clock after
// the byte is sampled.
// ----------------------------------------------------------------------------
module uart_rx_frame_parser #(
    parameter int unsigned                P_DATA_WIDTH  = 8,
    parameter logic [P_DATA_WIDTH-1:0]    P_HEAD0       = 8'h55,
    parameter logic [P_DATA_WIDTH-1:0]    P_HEAD1       = 8'hAA,
    parameter int unsigned                P_MAX_LEN     = 16,
    parameter int unsigned                P_TIMEOUT_CYC = 50000
) (
    input  logic                    clk,
    input  logic                    w_user_rst,
    input  logic [P_DATA_WIDTH-1:0] i_rx_data,
    input  logic                    i_rx_valid,
    output logic [P_DATA_WIDTH-1:0] o_pld_data,
    output logic                    o_pld_valid,
    output logic                    o_pld_last,
    output logic                    o_frame_ok,
    output logic                    o_frame_err,
    output logic [1:0]              o_err_code,
    output logic [15:0]             o_frame_cnt,
    output logic                    o_busy
);

    localparam int unsigned TIMER_W = $clog2(P_TIMEOUT_CYC);
    localparam logic [TIMER_W-1:0]      TIMER_MAX = TIMER_W'(P_TIMEOUT_CYC - 1);
    localparam logic [P_DATA_WIDTH-1:0] MAX_LEN   = P_DATA_WIDTH'(P_MAX_LEN);
    localparam logic [P_DATA_WIDTH-1:0] ONE       = P_DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StHead1,
        StLen,
        StPld,
        StChk
    } state_e;

    state_e                  state;
    logic [TIMER_W-1:0]      timer;
    logic [P_DATA_WIDTH-1:0] sum;
    logic [P_DATA_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge w_user_rst) begin
        if (w_user_rst) begin
            state       <= StIdle;
            timer       <= '0;
            sum         <= '0;
            cnt         <= '0;
            o_pld_data  <= '0;
            o_pld_valid <= 1'b0;
            o_pld_last  <= 1'b0;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            o_err_code  <= 2'd0;
            o_frame_cnt <= 16'd0;
            o_busy      <= 1'b0;
        end else begin
            // Strobes default low; they only pulse for one cycle.
            o_pld_valid <= 1'b0;
            o_pld_last  <= 1'b0;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;

            // Inter-byte silence timer: restarts on every accepted byte.
            if (state == StIdle || i_rx_valid) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            if (i_rx_valid) begin
                unique case (state)
                    StIdle: begin
                        if (i_rx_data == P_HEAD0) begin
                            state  <= StHead1;
                            o_busy <= 1'b1;
                        end
                    end
                    StHead1: begin
                        // A repeated HEAD0 keeps us waiting for HEAD1 (resync).
                        if (i_rx_data == P_HEAD1) begin
                            state <= StLen;
                        end else if (i_rx_data != P_HEAD0) begin
                            state  <= StIdle;
                            o_busy <= 1'b0;
                        end
                    end
                    StLen: begin
                        if (i_rx_data == '0 || i_rx_data > MAX_LEN) begin
                            o_frame_err <= 1'b1;
                            o_err_code  <= 2'd1;
                            state       <= StIdle;
                            o_busy      <= 1'b0;
                        end else begin
                            cnt   <= i_rx_data;
                            sum   <= i_rx_data;
                            state <= StPld;
                        end
                    end
                    StPld: begin
                        o_pld_data  <= i_rx_data;
                        o_pld_valid <= 1'b1;
                        sum         <= sum + i_rx_data;
                        cnt         <= cnt - ONE;
                        if (cnt == ONE) begin
                            o_pld_last <= 1'b1;
                            state      <= StChk;
                        end
                    end
                    StChk: begin
                        if (i_rx_data == sum) begin
                            o_frame_ok  <= 1'b1;
                            o_err_code  <= 2'd0;
                            o_frame_cnt <= o_frame_cnt + 16'd1;
                        end else begin
                            o_frame_err <= 1'b1;
                            o_err_code  <= 2'd2;
                        end
                        state  <= StIdle;
                        o_busy <= 1'b0;
                    end
                    default: begin
                        state  <= StIdle;
                        o_busy <= 1'b0;
                    end
                endcase
            end else if (state != StIdle && timer == TIMER_MAX) begin
                o_frame_err <= 1'b1;
                o_err_code  <= 2'd3;
                state       <= StIdle;
                o_busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_frame_parser
//
// Self-checking bench for uart_rx_frame_parser. Expected output events are
// derived from how each frame is built (payload list, computed checksum,
// corruption choice) and compared against a log of observed DUT events.
// ----------------------------------------------------------------------------
module tb_uart_rx_frame_parser;

    localparam int unsigned TMO = 100;

    logic        clk;
    logic        w_user_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_pld_data;
    logic        o_pld_valid;
    logic        o_pld_last;
    logic        o_frame_ok;
    logic        o_frame_err;
    logic [1:0]  o_err_code;
    logic [15:0] o_frame_cnt;
    logic        o_busy;

    uart_rx_frame_parser #(
        .P_DATA_WIDTH  (8),
        .P_HEAD0       (8'h55),
        .P_HEAD1       (8'hAA),
        .P_MAX_LEN     (16),
        .P_TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .w_user_rst  (w_user_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_pld_data  (o_pld_data),
        .o_pld_valid (o_pld_valid),
        .o_pld_last  (o_pld_last),
        .o_frame_ok  (o_frame_ok),
        .o_frame_err (o_frame_err),
        .o_err_code  (o_err_code),
        .o_frame_cnt (o_frame_cnt),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    int          gap_max;
    logic [15:0] exp_cnt;
    logic [7:0]  pl[$];
    // Event word: {type, data, 7'b0, last, code}; type 1=pld, 2=ok, 3=err, FF=ok&err.
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    // Event monitor: outputs change on posedge, sampled on negedge.
    always @(negedge clk) begin
        if (o_pld_valid) obs_q.push_back({8'd1, o_pld_data, 7'd0, o_pld_last, 8'd0});
        if (o_frame_ok && o_frame_err) obs_q.push_back({8'hFF, 24'd0});
        else if (o_frame_ok) obs_q.push_back({8'd2, 16'd0, 6'd0, o_err_code});
        else if (o_frame_err) obs_q.push_back({8'd3, 16'd0, 6'd0, o_err_code});
    end

    // Called at a negedge; returns at the negedge right after the byte is sampled.
    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    endtask

    // Sends a frame using the payload in pl; records the expected events.
    task automatic send_frame(input int len, input logic [7:0] chk_xor);
        int         s;
        logic [7:0] chk;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'(len));
        if (len == 0 || len > 16) begin
            exp_q.push_back({8'd3, 16'd0, 8'd1});
            return;
        end
        s = len;
        for (int i = 0; i < len; i++) begin
            s += int'(pl[i]);
            exp_q.push_back({8'd1, pl[i], 7'd0, 1'(i == len - 1), 8'd0});
            send_byte(pl[i]);
        end
        chk = 8'(s % 256) ^ chk_xor;
        send_byte(chk);
        if (chk_xor != 8'd0) begin
            exp_q.push_back({8'd3, 16'd0, 8'd2});
        end else begin
            exp_q.push_back({8'd2, 24'd0});
            exp_cnt++;
        end
    endtask

    task automatic test_reset;
        w_user_rst = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_pld_data, o_pld_valid, o_pld_last, o_frame_ok, o_frame_err} !== 12'd0) begin
            failures++;
            $display("FAIL reset_data_strobes: got %h, expected 000",
                     {o_pld_data, o_pld_valid, o_pld_last, o_frame_ok, o_frame_err});
        end
        checks++;
        if (o_err_code !== 2'd0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_code_busy: got code=%0d busy=%b, expected 0/0", o_err_code, o_busy);
        end
        checks++;
        if (o_frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d, expected 0", o_frame_cnt);
        end
        w_user_rst = 1'b0;
        exp_cnt    = 16'd0;
        @(negedge clk);
    endtask

    task automatic test_good_and_bad_chk;
        gap_max = 0;
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(3, 8'h00);          // chk 69
        send_frame(3, 8'h01);          // chk 68
        repeat (2) @(negedge clk);
        checks++;
        if (o_err_code !== 2'd2) begin
            failures++;
            $display("FAIL chk_code_held: got %0d, expected 2", o_err_code);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size()) begin
                failures++;
                $display("FAIL good_chk ev%0d: got none, expected %h", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL good_chk ev%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL good_chk count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (o_frame_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL good_chk frame_cnt: got %0d, expected %0d", o_frame_cnt, exp_cnt);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_bad_len;
        gap_max = 0;
        send_frame(0, 8'h00);
        send_frame(17, 8'h00);
        pl = '{8'hDE, 8'hAD, 8'h55, 8'hAA};
        send_frame(4, 8'h00);
        repeat (2) @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size()) begin
                failures++;
                $display("FAIL bad_len ev%0d: got none, expected %h", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bad_len ev%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL bad_len count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (o_frame_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL bad_len frame_cnt: got %0d, expected %0d", o_frame_cnt, exp_cnt);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_resync;
        logic [7:0] seq_a[6];
        logic [7:0] seq_b[8];
        gap_max = 0;
        seq_a = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
        foreach (seq_a[i]) send_byte(seq_a[i]);
        exp_q.push_back({8'd1, 8'h7E, 7'd0, 1'b1, 8'd0});
        exp_q.push_back({8'd2, 24'd0});
        exp_cnt++;
        // Broken header, then a frame body while idle: nothing must come out.
        seq_b = '{8'h55, 8'h12, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        foreach (seq_b[i]) send_byte(seq_b[i]);
        repeat (2) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL resync_busy: got %b, expected 0", o_busy);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size()) begin
                failures++;
                $display("FAIL resync ev%0d: got none, expected %h", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL resync ev%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL resync count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (o_frame_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL resync frame_cnt: got %0d, expected %0d", o_frame_cnt, exp_cnt);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_timeout;
        bit early;
        gap_max = 0;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h01);
        early = 1'b0;
        // Byte 01 was sampled at edge E0; error must appear after edge E(TMO).
        repeat (TMO - 1) begin
            @(negedge clk);
            if (o_frame_err) early = 1'b1;
        end
        checks++;
        if (early || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: got err_seen=%b busy=%b, expected 0/1", early, o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_frame_err !== 1'b1 || o_err_code !== 2'd3 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fire: got err=%b code=%0d busy=%b, expected 1/3/0",
                     o_frame_err, o_err_code, o_busy);
        end
        @(negedge clk);
        exp_q.delete();
        obs_q.delete();

        // Byte arriving on the threshold cycle is accepted instead.
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h01);
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'h02);
        send_byte(8'h05);
        exp_q.push_back({8'd1, 8'h01, 8'd0, 8'd0});
        exp_q.push_back({8'd1, 8'h02, 7'd0, 1'b1, 8'd0});
        exp_q.push_back({8'd2, 24'd0});
        exp_cnt++;
        repeat (2) @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size()) begin
                failures++;
                $display("FAIL no_timeout ev%0d: got none, expected %h", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL no_timeout ev%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL no_timeout count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (o_frame_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL no_timeout frame_cnt: got %0d, expected %0d", o_frame_cnt, exp_cnt);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_random;
        int         kind;
        int         len;
        logic [7:0] g;
        gap_max = 3;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'h55) g = 8'h00;
                send_byte(g);
            end
            kind = $urandom_range(0, 3);
            if (kind == 3) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
                send_frame(len, 8'h00);
            end else begin
                len = $urandom_range(1, 16);
                pl.delete();
                repeat (len) pl.push_back(8'($urandom_range(0, 255)));
                send_frame(len, (kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00);
            end
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size()) begin
                failures++;
                $display("FAIL random ev%0d: got none, expected %h", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random ev%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (o_frame_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL random frame_cnt: got %0d, expected %0d", o_frame_cnt, exp_cnt);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        gap_max = 0;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h11);
        w_user_rst = 1'b1;
        #1;
        checks++;
        if (o_pld_valid !== 1'b0 || o_pld_data !== 8'h00 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: got valid=%b data=%h busy=%b, expected 0/00/0",
                     o_pld_valid, o_pld_data, o_busy);
        end
        checks++;
        if (o_frame_cnt !== 16'd0 || o_err_code !== 2'd0) begin
            failures++;
            $display("FAIL midrst_cnt_code: got cnt=%0d code=%0d, expected 0/0",
                     o_frame_cnt, o_err_code);
        end
        @(negedge clk);
        w_user_rst = 1'b0;
        exp_cnt    = 16'd0;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(3, 8'h00);
        repeat (2) @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size()) begin
                failures++;
                $display("FAIL midrst ev%0d: got none, expected %h", i, exp_q[i]);
            end else if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL midrst ev%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL midrst count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (o_frame_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL midrst frame_cnt: got %0d, expected %0d", o_frame_cnt, exp_cnt);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        gap_max  = 0;
        test_reset();
        test_good_and_bad_chk();
        test_bad_len();
        test_resync();
        test_timeout();
        test_random();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
